// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_pkg
// Description : Shared types and constants for the memory responder: FSM
//               state encoding, default geometry and wait-state counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    // Responder access states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Default address width (memory depth is 2**c_def_addr_w bytes).
    localparam int c_def_addr_w      = 16;
    // Default number of extra access cycles.
    localparam int c_def_wait_states = 2;
    // Counter wide enough for the full 0..7 wait-state range.
    localparam int c_cnt_w           = 3;

endpackage : mem_resp_pkg
`default_nettype wire

// File: rtl/mar_reg.sv
`default_nettype none
// ============================================================================
// Module      : mar_reg
// Description : Memory address register with synchronous clear, parallel load
//               and +1 increment (wrapping). Priority: clr > load > inc.
// Revision    : 1.0 - initial release
// ============================================================================
module mar_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         i_load,
    input  logic         i_inc,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Address register: a load always beats an increment requested the same cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_inc) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule : mar_reg
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder
// Description : Byte-wide memory slave with a MAR, programmable wait states
//               and an IDLE/RD_WAIT/WR_WAIT/DONE handshake FSM.
//               Optional macro MAR_AUTOINC_EN: MAR increments by one at the
//               end of every DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = c_def_addr_w,
    parameter int WAIT_STATES = c_def_wait_states
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              La,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [7:0]        wr_data,
    output logic [7:0]        rd_data,
    output logic              Lm,
    output logic              Em,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] mar_q
);

    // Counter value on the final wait-state cycle.
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(WAIT_STATES);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [7:0]           r_rd_data;
    logic                 r_lm;
    logic                 r_em;
    logic                 r_ack;
    logic                 r_busy;
    logic [7:0]           r_mem [0:(2**ADDR_W)-1];

    logic                 w_mar_load;
    logic                 w_mar_inc;
    logic                 w_last_wait;
    logic                 w_commit;

    // MAR only listens to La while idle, so the address is frozen for the access.
    assign w_mar_load  = (r_state == IDLE) && La;
    assign w_last_wait = (r_cnt == c_wait_last);
    // clr on the final write edge aborts the write as well.
    assign w_commit    = !clr && (r_state == WR_WAIT) && w_last_wait;

`ifdef MAR_AUTOINC_EN
    assign w_mar_inc = (r_state == DONE);
`else
    assign w_mar_inc = 1'b0;
`endif

    mar_reg #(
        .W (ADDR_W)
    ) u_mar (
        .clk    (clk),
        .clr    (clr),
        .i_load (w_mar_load),
        .i_inc  (w_mar_inc),
        .i_d    (addr_in),
        .o_q    (mar_q)
    );

    // Storage array: deliberately not reset so clr leaves contents intact.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[mar_q] <= wr_data;
        end
    end

    // Access FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd_data <= 8'h00;
            r_lm      <= 1'b0;
            r_em      <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_lm  <= 1'b0;
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    // Read wins when both requests are raised together.
                    if (rd_req) begin
                        r_state <= RD_WAIT;
                        r_busy  <= 1'b1;
                    end else if (wr_req) begin
                        r_state <= WR_WAIT;
                        r_busy  <= 1'b1;
                        r_em    <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (w_last_wait) begin
                        r_state   <= DONE;
                        r_cnt     <= '0;
                        r_rd_data <= r_mem[mar_q];
                        r_lm      <= 1'b1;
                        r_ack     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                WR_WAIT: begin
                    if (w_last_wait) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        r_em    <= 1'b0;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                DONE: begin
                    // Unconditional return guarantees an idle cycle between accesses.
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_em    <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign Lm      = r_lm;
    assign Em      = r_em;
    assign ack     = r_ack;
    assign busy    = r_busy;

endmodule : memory_responder
`default_nettype wire

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: address width; memory depth is 2^ADDR_W bytes.
REQ-002 SHALL have parameter WAIT_STATES, default 2: extra access cycles, legal range 0..7.
REQ-003 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port La  in  1  load the address register (MAR) from addr_in.
REQ-006 SHALL have port addr_in  in  ADDR_W  address from the bus.
REQ-007 SHALL have port rd_req  in  1  read request, level.
REQ-008 SHALL have port wr_req  in  1  write request, level.
REQ-009 SHALL have port wr_data  in  8  write data from the data-register memory side.
REQ-010 SHALL have port rd_data  out  8  registered read data toward the data-register memory side.
REQ-011 SHALL have port Lm  out  1  load strobe for the data register, one cycle, read completion.
REQ-012 SHALL have port Em  out  1  enable request for the data register's memory-side output during writes.
REQ-013 SHALL have port ack  out  1  one-cycle completion pulse, read or write.
REQ-014 SHALL have port busy  out  1  high while an access is in progress.
REQ-015 SHALL have port mar_q  out  ADDR_W  current MAR value.

Function
REQ-016 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT, DONE.
REQ-017 IDLE SHALL accept a request at a rising edge when rd_req or wr_req is high, and SHALL move to RD_WAIT or WR_WAIT.
REQ-018 If rd_req and wr_req are both high in IDLE, the read SHALL win and the write SHALL be dropped.
REQ-019 The access address SHALL be latched at acceptance; if La is high in the same cycle, the access SHALL use addr_in (bypass) and the MAR SHALL load it.
REQ-020 RD_WAIT/WR_WAIT SHALL last WAIT_STATES+1 cycles, counted by an internal counter, then go to DONE.
REQ-021 A write SHALL hold Em high for all of WR_WAIT and SHALL commit wr_data to memory at the final WR_WAIT edge.
REQ-022 A read SHALL register mem[addr] into rd_data at the final RD_WAIT edge; rd_data SHALL hold until the next read completes.
REQ-023 DONE SHALL last exactly one cycle, with ack=1, and Lm=1 for reads only; it SHALL then return to IDLE.
REQ-024 Acceptance-to-ack latency SHALL be WAIT_STATES+2 cycles; IDLE SHALL be visited for at least one cycle between accesses.
REQ-025 busy SHALL be high in RD_WAIT, WR_WAIT and DONE, and low in IDLE.
REQ-026 Requests outside IDLE SHALL be ignored and not queued.
REQ-027 La outside IDLE SHALL be ignored, so the MAR is frozen during an access.
REQ-028 A request still held high after ack SHALL start a new access from IDLE; requesters drop the request on ack.

Reset
REQ-029 clr high at a rising edge SHALL force IDLE and set mar_q=0, rd_data=0, Lm=0, Em=0, ack=0, busy=0, and the counter to 0.
REQ-030 clr mid-access SHALL abort the access with no memory write, no ack and no Lm.
REQ-031 clr SHALL NOT clear memory contents.
REQ-032 clr SHALL dominate La and requests in the same cycle.

Configuration
REQ-033 With MAR_AUTOINC_EN defined, the MAR SHALL increment by 1 at each DONE cycle, wrapping from 2^ADDR_W-1 to 0.
REQ-034 With MAR_AUTOINC_EN undefined, the MAR SHALL change only on La or clr.
REQ-035 With MAR_AUTOINC_EN defined, La in IDLE SHALL take precedence over a pending increment.

Structure
REQ-036 Package mem_resp_pkg SHALL hold the FSM state enum, the default ADDR_W/WAIT_STATES constants and the counter width.
REQ-037 The MAR SHALL be a separate sub-module mar_reg (load, increment, clear) instantiated once.

Verification
REQ-038 Bench SHALL cover: clr=1 for 1 cycle -> all outputs 0, busy=0, mar_q=0000.
REQ-039 Bench SHALL cover: La with addr_in=0x0010, then wr_req with wr_data=0xA5, WAIT_STATES=2 -> Em high 3 cycles, ack at acceptance+4; then rd_req -> rd_data=0xA5, Lm=ack=1 for one cycle.
REQ-040 Bench SHALL cover: rd_req=wr_req=1 at 0x0020, which holds 0x3C, with wr_data=0xFF -> read served, rd_data=0x3C, mem[0x0020] still 0x3C.
REQ-041 Bench SHALL cover: clr asserted during the second WR_WAIT cycle of a write of 0x77 to 0x0030 -> no ack, mem[0x0030] unchanged, rd_data=0.
REQ-042 Bench SHALL cover: La with addr_in=0x0040 during RD_WAIT -> ignored, mar_q unchanged until IDLE.
REQ-043 Bench SHALL cover, with MAR_AUTOINC_EN: MAR=0xFFFF, read completes -> mar_q=0x0000 after DONE; without the macro, mar_q stays 0xFFFF.
